// File: rtl/router_pkg.sv
// router_pkg: shared widths, header field positions and FSM state encoding for the 1x3 router
package router_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_W = 2;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = ADDR_LSB + ADDR_W - 1;
    localparam int LEN_LSB = ADDR_W;
    localparam int LEN_MSB = DATA_WIDTH - 1;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } state_t;
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return a != ADDR_INVALID;
    endfunction
endpackage

// File: rtl/router_parity.sv
// router_parity: running XOR accumulator with clear and enable
module router_parity #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] par
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            par <= '0;
        else if (clr)
            par <= '0;
        else if (en)
            par <= par ^ din;
endmodule

// File: rtl/router_reg.sv
// router_reg: router datapath register stage - header latch, full-hold byte, parity check
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);
    import router_pkg::*;
    logic [DATA_WIDTH-1:0] hdr, hold, pkt_par, int_par;
    logic hdr_ok;
    assign hdr_ok = detect_add & pkt_valid & addr_ok(data_in[ADDR_MSB:ADDR_LSB]);
    router_parity #(.W(DATA_WIDTH)) u_parity (
        .clk    (clk),
        .resetn (resetn),
        .clr    (hdr_ok),
        .en     (lfd_state | (ld_state & pkt_valid)),
        .din    (lfd_state ? hdr : data_in),
        .par    (int_par)
    );
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            hdr           <= '0;
            hold          <= '0;
            pkt_par       <= '0;
            dout          <= '0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
        end else if (!full_state) begin
            if (hdr_ok)
                hdr <= data_in;
            if (lfd_state)
                dout <= hdr;
            else if (ld_state & ~fifo_full)
                dout <= data_in;
            else if (laf_state)
                dout <= hold;
            if (ld_state & fifo_full)
                hold <= data_in;
            if (ld_state & ~pkt_valid)
                pkt_par <= data_in;
            if (rst_int_reg)
                low_pkt_valid <= 1'b0;
            else if (ld_state & ~pkt_valid)
                low_pkt_valid <= 1'b1;
            // a parity byte parked in hold completes only once LOAD_AFTER_FULL drains it
            if (detect_add)
                parity_done <= 1'b0;
            else if ((ld_state & ~fifo_full & ~pkt_valid) | (laf_state & low_pkt_valid & ~parity_done))
                parity_done <= 1'b1;
            if (hdr_ok)
                err <= 1'b0;
            else if (rst_int_reg)
                err <= int_par != pkt_par;
        end
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: table-driven per-cycle vectors with an expected-result queue, plus corner sequences
module tb_router_reg;
    import router_pkg::*;
    typedef struct {
        state_t     st;
        logic       pv;
        logic       full;
        logic [7:0] din;
        logic [7:0] dout;
        logic       pd;
        logic       lpv;
        logic       err;
        logic [7:0] hold;
    } vec_t;
    typedef struct {
        logic [7:0] dout;
        logic       pd;
        logic       lpv;
        logic       err;
        logic [7:0] hold;
    } exp_t;

    logic clk = 0, resetn = 0, pkt_valid = 0, fifo_full = 0;
    logic detect_add = 0, lfd_state = 0, ld_state = 0, laf_state = 0, full_state = 0, rst_int_reg = 0;
    logic [7:0] data_in = 0, dout;
    logic parity_done, low_pkt_valid, err;
    vec_t tab[$];
    exp_t sb[$];
    int checks = 0, errors = 0, na;

    router_reg #(.DATA_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    function automatic void add(state_t st, logic pv, logic full, logic [7:0] din,
                                logic [7:0] d, logic pd, logic lpv, logic e, logic [7:0] h);
        tab.push_back('{st, pv, full, din, d, pd, lpv, e, h});
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set(state_t st, logic pv, logic full, logic [7:0] din);
        detect_add  = st == DECODE_ADDRESS;
        lfd_state   = st == LOAD_FIRST_DATA;
        ld_state    = st == LOAD_DATA;
        laf_state   = st == LOAD_AFTER_FULL;
        full_state  = st == FIFO_FULL_STATE;
        rst_int_reg = st == CHECK_PARITY_ERROR;
        pkt_valid   = pv;
        fifo_full   = full;
        data_in     = din;
    endtask

    task automatic step(state_t st, logic pv, logic full, logic [7:0] din);
        set(st, pv, full, din);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(int i);
        exp_t e;
        vec_t v = tab[i];
        sb.push_back('{v.dout, v.pd, v.lpv, v.err, v.hold});
        step(v.st, v.pv, v.full, v.din);
        e = sb.pop_front();
        checks++;
        if (dout !== e.dout || parity_done !== e.pd || low_pkt_valid !== e.lpv || err !== e.err || dut.hold !== e.hold) begin
            errors++;
            $display("FAIL vec%0d %s: got dout=%h pd=%b lpv=%b err=%b hold=%h expected dout=%h pd=%b lpv=%b err=%b hold=%h",
                     i, v.st.name(), dout, parity_done, low_pkt_valid, err, dut.hold,
                     e.dout, e.pd, e.lpv, e.err, e.hold);
        end
    endtask

    initial begin
        // clean packet 0D,11,22,33 parity 0D
        add(DECODE_ADDRESS,     1, 0, 8'h0D, 8'h00, 0, 0, 0, 8'h00);
        add(LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h0D, 0, 0, 0, 8'h00);
        add(LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0, 8'h00);
        add(LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0, 8'h00);
        add(LOAD_DATA,          1, 0, 8'h33, 8'h33, 0, 0, 0, 8'h00);
        add(LOAD_DATA,          0, 0, 8'h0D, 8'h0D, 1, 1, 0, 8'h00);
        add(LOAD_PARITY,        0, 0, 8'h0D, 8'h0D, 1, 1, 0, 8'h00);
        add(CHECK_PARITY_ERROR, 0, 0, 8'h0D, 8'h0D, 1, 0, 0, 8'h00);
        // fifo full while 22 is sampled
        add(DECODE_ADDRESS,     1, 0, 8'h0D, 8'h0D, 0, 0, 0, 8'h00);
        add(LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h0D, 0, 0, 0, 8'h00);
        add(LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0, 8'h00);
        add(LOAD_DATA,          1, 1, 8'h22, 8'h11, 0, 0, 0, 8'h22);
        add(FIFO_FULL_STATE,    1, 1, 8'h33, 8'h11, 0, 0, 0, 8'h22);
        add(LOAD_AFTER_FULL,    1, 0, 8'h33, 8'h22, 0, 0, 0, 8'h22);
        add(LOAD_DATA,          1, 0, 8'h33, 8'h33, 0, 0, 0, 8'h22);
        add(LOAD_DATA,          0, 0, 8'h0D, 8'h0D, 1, 1, 0, 8'h22);
        add(LOAD_PARITY,        0, 0, 8'h0D, 8'h0D, 1, 1, 0, 8'h22);
        add(CHECK_PARITY_ERROR, 0, 0, 8'h0D, 8'h0D, 1, 0, 0, 8'h22);
        // fifo full while the parity byte is sampled
        add(DECODE_ADDRESS,     1, 0, 8'h0D, 8'h0D, 0, 0, 0, 8'h22);
        add(LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h0D, 0, 0, 0, 8'h22);
        add(LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0, 8'h22);
        add(LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0, 8'h22);
        add(LOAD_DATA,          1, 0, 8'h33, 8'h33, 0, 0, 0, 8'h22);
        add(LOAD_DATA,          0, 1, 8'h0D, 8'h33, 0, 1, 0, 8'h0D);
        add(FIFO_FULL_STATE,    0, 1, 8'h0D, 8'h33, 0, 1, 0, 8'h0D);
        add(LOAD_AFTER_FULL,    0, 0, 8'h0D, 8'h0D, 1, 1, 0, 8'h0D);
        add(CHECK_PARITY_ERROR, 0, 0, 8'h0D, 8'h0D, 1, 0, 0, 8'h0D);
        // bad parity FF
        add(DECODE_ADDRESS,     1, 0, 8'h0D, 8'h0D, 0, 0, 0, 8'h0D);
        add(LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h0D, 0, 0, 0, 8'h0D);
        add(LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0, 8'h0D);
        add(LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0, 8'h0D);
        add(LOAD_DATA,          1, 0, 8'h33, 8'h33, 0, 0, 0, 8'h0D);
        add(LOAD_DATA,          0, 0, 8'hFF, 8'hFF, 1, 1, 0, 8'h0D);
        add(LOAD_PARITY,        0, 0, 8'hFF, 8'hFF, 1, 1, 0, 8'h0D);
        add(CHECK_PARITY_ERROR, 0, 0, 8'hFF, 8'hFF, 1, 0, 1, 8'h0D);
        na = tab.size();
        // post-reset packet 04,AA parity AE
        add(DECODE_ADDRESS,     1, 0, 8'h04, 8'h00, 0, 0, 0, 8'h00);
        add(LOAD_FIRST_DATA,    1, 0, 8'hAA, 8'h04, 0, 0, 0, 8'h00);
        add(LOAD_DATA,          1, 0, 8'hAA, 8'hAA, 0, 0, 0, 8'h00);
        add(LOAD_DATA,          0, 0, 8'hAE, 8'hAE, 1, 1, 0, 8'h00);
        add(LOAD_PARITY,        0, 0, 8'hAE, 8'hAE, 1, 1, 0, 8'h00);
        add(CHECK_PARITY_ERROR, 0, 0, 8'hAE, 8'hAE, 1, 0, 0, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", dout, 8'h00);
        chk("reset_flags", {5'b0, parity_done, low_pkt_valid, err}, 8'h00);
        resetn = 1;
        for (int i = 0; i < na; i++) run_vec(i);

        step(DECODE_ADDRESS, 1, 0, 8'h0F);
        chk("inv_hdr_hdr", dut.hdr, 8'h0D);
        chk("inv_hdr_int_par", dut.int_par, 8'h0D);
        chk("inv_hdr_err", {7'b0, err}, 8'h01);
        step(DECODE_ADDRESS, 1, 0, 8'h0D);
        chk("hdr_clears_err", {7'b0, err}, 8'h00);
        step(LOAD_FIRST_DATA, 1, 0, 8'h11);
        step(LOAD_DATA, 1, 0, 8'h11);
        chk("pre_reset_dout", dout, 8'h11);
        chk("pre_reset_int_par", dut.int_par, 8'h1C);
        #3 resetn = 0;
        set(LOAD_PARITY, 0, 0, 8'h00);
        #1;
        chk("async_rst_dout", dout, 8'h00);
        chk("async_rst_flags", {5'b0, parity_done, low_pkt_valid, err}, 8'h00);
        chk("async_rst_int_par", dut.int_par, 8'h00);
        chk("async_rst_hdr", dut.hdr, 8'h00);
        @(posedge clk);
        #1 resetn = 1;

        for (int i = na; i < tab.size(); i++) run_vec(i);
        chk("sb_empty", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage of the 1x3 router. Sits between the input port and the three output FIFOs, downstream of the router FSM. It latches the header, presents bytes on `dout` for FIFO write, holds one byte when the target FIFO fills, and accumulates and checks packet parity. It returns `parity_done` and `low_pkt_valid` to the FSM and flags `err` on parity mismatch.

## Interface
- `DATA_WIDTH`, 8, byte width of `data_in`/`dout`; header address field is always bits [1:0].
- `clk` in 1: single clock, all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: high from header through last payload byte; low on the parity byte.
- `data_in` in DATA_WIDTH: packet byte from source.
- `fifo_full` in 1: full flag of the FIFO selected by the current address.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` in 1 each: FSM state decodes; one-hot or all-zero.
- `dout` out DATA_WIDTH: byte to FIFO write port; written when FSM `write_en_reg`/`lfd_state`.
- `parity_done` out 1: parity byte has been presented on `dout`.
- `low_pkt_valid` out 1: parity byte received (pkt_valid fell).
- `err` out 1: packet parity mismatch.

## Operation
- Packet: header {len[7:2], addr[1:0]}, addr 2'b11 invalid; 1..63 payload bytes; parity byte = XOR of header and all payload bytes.
- Internal registers: `hdr`, `hold`, `int_par`, `pkt_par`, all reset 0.
- `detect_add & pkt_valid & data_in[1:0]!=2'b11`: `hdr<=data_in`; `int_par<=0`; `err<=0`.
- `lfd_state`: `dout<=hdr`; `int_par<=int_par^hdr`.
- `ld_state & ~fifo_full`: `dout<=data_in`.
- `ld_state & fifo_full`: `hold<=data_in`; `dout` holds.
- `ld_state & pkt_valid`: `int_par<=int_par^data_in`. Each payload byte is XORed exactly once, whether it went to `dout` or `hold`.
- `ld_state & ~pkt_valid`: `pkt_par<=data_in`; `low_pkt_valid<=1`.
- `laf_state`: `dout<=hold`.
- `full_state`: no register changes; `dout` and `hold` stable.
- `parity_done`:
  - Set on `ld_state & ~fifo_full & ~pkt_valid`.
  - Set on `laf_state & low_pkt_valid & ~parity_done` (parity byte was the held byte).
  - Cleared on `detect_add`.
- `low_pkt_valid`: cleared on `rst_int_reg`.
- `err`: on `rst_int_reg`, `err<=(int_par!=pkt_par)`. Holds until the next accepted header.
- Invalid header (addr 2'b11): no register changes.
- Priority within a cycle: reset > state-decode actions. State decodes are mutually exclusive, so no conflicts arise.

## Timing
- All outputs reset to 0 asynchronously; `resetn` deassertion is synchronised upstream.
- Header byte to `dout`: 2 cycles (DECODE capture, LFD present).
- Payload byte to `dout`: 1 cycle (registered in LOAD_DATA).
- FIFO-full path: byte lands in `hold` in LOAD_DATA, sits through FIFO_FULL, and reaches `dout` 1 cycle after LOAD_AFTER_FULL is entered.
- `parity_done`/`low_pkt_valid` are visible to the FSM the cycle after the parity byte is sampled. This is the condition for LOAD_DATA->LOAD_PARITY and LOAD_AFTER_FULL exits.
- `err` is valid the cycle after CHECK_PARITY_ERROR.
- Reset mid-packet clears all state; the next byte must be a header.
- Soft reset is handled by the FSM returning to DECODE; the next `detect_add` reinitialises parity and `err`.

## Structure
- Shared `router_pkg`: `DATA_WIDTH`, `ADDR_W=2`, `ADDR_INVALID=2'b11`, header field positions.
  - The FSM state encoding constants also move here so the state-decode meaning is single-sourced.
- One sub-module: `router_parity`. XOR accumulator with clear, enable and byte input; outputs running parity.
- All else stays flat in `router_reg`.

## Test plan
- Header 8'h0D (len 3, addr 1), payload 8'h11, 8'h22, 8'h33, parity 8'h0D^11^22^33=8'h0D, FIFO never full:
  - `dout` sequence 0D,11,22,33,0D.
  - `parity_done` rises the cycle after parity is sampled.
  - `err=0` after CHECK_PARITY_ERROR.
- Same packet with parity byte 8'hFF -> `err=1` after CHECK_PARITY_ERROR; cleared when the next valid header is accepted.
- `fifo_full` high while payload 8'h22 is sampled -> `hold=8'h22`, `dout` stays 8'h11 through FIFO_FULL; `dout=8'h22` after LOAD_AFTER_FULL; final parity still matches, `err=0`.
- `fifo_full` high when the parity byte is sampled -> `low_pkt_valid=1`, `parity_done=0` until LOAD_AFTER_FULL, then `parity_done=1` and `dout=parity`.
- Header 8'h0F (addr 3) with `detect_add` -> `hdr`, `int_par`, `err` unchanged.
- Assert `resetn=0` mid-payload, asynchronously between edges -> `dout`, `parity_done`, `low_pkt_valid`, `err` all 0 immediately; next packet 8'h04, 8'hAA, parity 8'hAE checks clean.
